move_core: RTL and testbench
============================

MOVE_CORE -- requirements
Module: move_core

Interface
REQ-001 SHALL have parameter BITNESS, default 16: datapath/PC width, 8..32.
REQ-002 SHALL have parameter NDREGS, default 32: data registers, power of two, 2..32.
REQ-003 SHALL have parameter NPIN, default 2: pin channels, 1..2.
REQ-004 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port pc  out  BITNESS  instruction address (registered).
REQ-007 SHALL have port instruction  in  16  instruction word for current pc.
REQ-008 SHALL have port instr_valid  in  1  instruction word valid this cycle.
REQ-009 SHALL have port pin_in  in  NPIN*BITNESS  input channels, channel c at bits [c*BITNESS +: BITNESS].
REQ-010 SHALL have port pin_in_valid  in  NPIN  per-channel input data available.
REQ-011 SHALL have port pin_in_ack  out  NPIN  one-cycle pulse; channel input consumed.
REQ-012 SHALL have port pin_out  out  NPIN*BITNESS  registered output channels, same packing.
REQ-013 SHALL have port pin_out_strobe  out  NPIN  one-cycle pulse; channel written.
REQ-014 SHALL have port halted  out  1  core is in HALT.

Function
REQ-015 SHALL decode instruction as i1=[15], D=[14:8], i0=[7], S=[6:0].
REQ-016 SHALL map 7-bit address A as: A[6:5]=00 -> data reg A[4:0] mod NDREGS; 7'h40 -> PC; 7'h41/7'h42 -> pin channel 0/1; 7'h43 -> cycle counter (read-only); 7'h7F -> halt (write-only); all else reads 0, write ignored.
REQ-017 SHALL reserve pin channel 1 when NPIN=1: it reads 0 and ignores writes.
REQ-018 SHALL select source value = zero-extended S when i0=1; else the value read at address S.
REQ-019 SHALL read PC as pc+1, mod 2^BITNESS.
REQ-020 SHALL force write value to 0 when i0=0, i1=1 and S==D (clear idiom); i1 otherwise has no effect.
REQ-021 SHALL commit one instruction per cycle in RUN when instr_valid=1 and no pin stall; commit = destination write plus pc update.
REQ-022 SHALL update pc to write value when D=7'h40, else to pc+1 (wraps to 0).
REQ-023 SHALL stall (no write, pc held, no ack, no strobe) when instr_valid=0, or when i0=0 and S is pin channel c with pin_in_valid[c]=0.
REQ-024 SHALL pulse pin_in_ack[c] for exactly the committing cycle when source is pin channel c.
REQ-025 SHALL latch write value into pin_out channel c and pulse pin_out_strobe[c] in the cycle after a committing write to channel c.
REQ-026 SHALL make data register writes visible to the next committed instruction; D==S with a data register reads the old value.
REQ-027 SHALL increment the cycle counter on every cycle in RUN, including stalls, wrapping mod 2^BITNESS.
REQ-028 SHALL implement states RUN and HALT: a committing write to 7'h7F moves RUN->HALT; HALT exits only via rst.
REQ-029 SHALL in HALT hold pc, registers, counter and pin_out; assert halted=1; drive ack/strobe 0.
REQ-030 SHALL complete the halt-instruction's pc update (pc+1) before freezing.

Reset
REQ-031 SHALL on rst=1 at a clock edge set pc=0, all data registers=0, counter=0, pin_out=0, pin_in_ack=0, pin_out_strobe=0, halted=0, state=RUN; rst overrides any commit or stall that cycle.
REQ-032 SHALL begin fetching at pc=0 on the first cycle after rst deasserts.

Verification
REQ-033 SHALL cover immediate and move: 0x0185 (r1<=5), then 0x0201 (r2<=r1) -> r2=5, pc=2, counter=2.
REQ-034 SHALL cover jump and clear: 0x4085 at pc=0 -> pc=5; 0x8303 (r3 clear) -> r3=0.
REQ-035 SHALL cover pin stall: 0x0441 with pin_in_valid[0]=0 for 3 cycles, then 1 and data 0xBEEF -> pc held 3 cycles, r4=0xBEEF, pin_in_ack[0] single pulse.
REQ-036 SHALL cover pin output: r1=5, 0x4101 -> pin_out ch0=5 and one strobe pulse; no strobe on ch1.
REQ-037 SHALL cover halt and wrap: pc=0xFFFF with BITNESS=16 executing a move wraps pc to 0; a write to 7'h7F sets halted=1 and freezes pc; rst mid-HALT restores all reset values.
REQ-038 SHALL cover fetch stall: instr_valid=0 for 2 cycles -> no state change except counter +2.

Source files
------------

// File: rtl/move_core.sv
// move_core: single-instruction (move) processor core.
// Each 16-bit instruction moves a source value (a 7-bit immediate or the value
// read at address S) to the destination address D. The address space holds the
// data registers, the PC, the pin channels, a free-running cycle counter and a
// halt trigger.
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   pc                            registered instruction address
//   instruction, instr_valid      fetched word for pc and its valid flag
//   pin_in, pin_in_valid          packed input channels and their data-available flags
//   pin_in_ack                    pulse in the cycle a channel input is consumed
//   pin_out, pin_out_strobe       registered output channels and their write pulses
//   halted                        core is in HALT
module move_core #(
  parameter int unsigned BITNESS = 16,
  parameter int unsigned NDREGS  = 32,
  parameter int unsigned NPIN    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [BITNESS-1:0]      pc,
  input  logic [15:0]             instruction,
  input  logic                    instr_valid,
  input  logic [NPIN*BITNESS-1:0] pin_in,
  input  logic [NPIN-1:0]         pin_in_valid,
  output logic [NPIN-1:0]         pin_in_ack,
  output logic [NPIN*BITNESS-1:0] pin_out,
  output logic [NPIN-1:0]         pin_out_strobe,
  output logic                    halted
);

  localparam int unsigned RAW    = $clog2(NDREGS);
  localparam logic [6:0]  A_PC   = 7'h40;
  localparam logic [6:0]  A_PIN0 = 7'h41;
  localparam logic [6:0]  A_CNT  = 7'h43;
  localparam logic [6:0]  A_HALT = 7'h7F;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e             state_q, state_d;
  logic [BITNESS-1:0] pc_q, pc_d;
  logic [BITNESS-1:0] cnt_q, cnt_d;
  logic [BITNESS-1:0] regs_q [NDREGS];
  logic [BITNESS-1:0] regs_d [NDREGS];
  logic [BITNESS-1:0] pout_q [NPIN];
  logic [BITNESS-1:0] pout_d [NPIN];
  logic [NPIN-1:0]    strobe_q, strobe_d;
  logic [NPIN-1:0]    ack_c;

  logic               i1, i0;
  logic [6:0]         d_addr, s_addr;
  logic [BITNESS-1:0] rd_val, src_val, wr_val;
  logic [NPIN-1:0]    src_pin;
  logic               pin_stall, commit;

  assign {i1, d_addr, i0, s_addr} = instruction;

  // Source read mux; channels beyond NPIN never match, so they read 0 and never stall.
  always_comb begin : read_mux
    rd_val  = '0;
    src_pin = '0;
    if (s_addr[6:5] == 2'b00) begin
      rd_val = regs_q[RAW'(s_addr[4:0])];
    end else if (s_addr == A_PC) begin
      rd_val = pc_q + BITNESS'(1);
    end else if (s_addr == A_CNT) begin
      rd_val = cnt_q;
    end
    for (int c = 0; c < int'(NPIN); c++) begin
      if (s_addr == 7'(int'(A_PIN0) + c)) begin
        rd_val     = pin_in[c*BITNESS +: BITNESS];
        src_pin[c] = ~i0;
      end
    end
  end

  assign src_val   = i0 ? BITNESS'(s_addr) : rd_val;
  assign pin_stall = |(src_pin & ~pin_in_valid);
  // Clear idiom: register-sourced move with i1 set and S == D writes zero.
  assign wr_val    = (!i0 && i1 && (s_addr == d_addr)) ? '0 : src_val;
  assign commit    = !rst && (state_q == ST_RUN) && instr_valid && !pin_stall;

  // Next-state logic: counter runs in RUN even while stalled; commit writes D and advances pc.
  always_comb begin : next_state
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    regs_d   = regs_q;
    pout_d   = pout_q;
    strobe_d = '0;
    ack_c    = '0;
    if (state_q == ST_RUN) begin
      cnt_d = cnt_q + BITNESS'(1);
    end
    if (commit) begin
      pc_d  = pc_q + BITNESS'(1);
      ack_c = src_pin;
      if (d_addr[6:5] == 2'b00) begin
        regs_d[RAW'(d_addr[4:0])] = wr_val;
      end else if (d_addr == A_PC) begin
        pc_d = wr_val;
      end else if (d_addr == A_HALT) begin
        state_d = ST_HALT;
      end
      for (int c = 0; c < int'(NPIN); c++) begin
        if (d_addr == 7'(int'(A_PIN0) + c)) begin
          pout_d[c]   = wr_val;
          strobe_d[c] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
      for (int i = 0; i < int'(NDREGS); i++) regs_q[i] <= '0;
      for (int c = 0; c < int'(NPIN); c++) pout_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      regs_q   <= regs_d;
      pout_q   <= pout_d;
    end
  end

  // Output packing.
  always_comb begin : out_pack
    pin_out = '0;
    for (int c = 0; c < int'(NPIN); c++) pin_out[c*BITNESS +: BITNESS] = pout_q[c];
  end

  assign pc             = pc_q;
  assign halted         = (state_q == ST_HALT);
  assign pin_in_ack     = ack_c;
  assign pin_out_strobe = strobe_q;

endmodule

// File: tb/tb_move_core.sv
// Testbench for move_core (default parameters: 16-bit, 32 registers, 2 pins).
module tb_move_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [31:0] pin_in;
  logic [1:0]  pin_in_valid;
  logic [1:0]  pin_in_ack;
  logic [31:0] pin_out;
  logic [1:0]  pin_out_strobe;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  // Architectural reference state.
  logic [15:0] m_regs [32];
  logic [15:0] m_pc, m_cnt;
  logic [15:0] m_pout [2];
  logic [1:0]  m_strobe;
  logic        m_halt;

  always #5 clk = ~clk;

  move_core dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .pin_in         (pin_in),
    .pin_in_valid   (pin_in_valid),
    .pin_in_ack     (pin_in_ack),
    .pin_out        (pin_out),
    .pin_out_strobe (pin_out_strobe),
    .halted         (halted)
  );

  // Interprets one instruction the way the ISA describes it.
  task automatic model_step(input logic [15:0] ins, input logic iv, input logic [31:0] pd,
                            input logic [1:0] pv, input logic r, output logic [1:0] ae);
    logic        mi1, mi0, stall;
    logic [6:0]  d, s;
    logic [15:0] src, w, npc;
    ae       = 2'b00;
    m_strobe = 2'b00;
    if (r) begin
      m_pc = 0; m_cnt = 0; m_halt = 0; m_pout[0] = 0; m_pout[1] = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else if (!m_halt) begin
      mi1 = ins[15]; d = ins[14:8]; mi0 = ins[7]; s = ins[6:0];
      if (mi0)          src = {9'd0, s};
      else if (s < 32)  src = m_regs[s];
      else if (s == 64) src = m_pc + 16'd1;
      else if (s == 65) src = pd[15:0];
      else if (s == 66) src = pd[31:16];
      else if (s == 67) src = m_cnt;
      else              src = 0;
      stall = !iv || (!mi0 && ((s == 65 && !pv[0]) || (s == 66 && !pv[1])));
      if (!stall) begin
        w     = (!mi0 && mi1 && s == d) ? 16'd0 : src;
        ae[0] = !mi0 && s == 65;
        ae[1] = !mi0 && s == 66;
        npc   = m_pc + 16'd1;
        if (d < 32)        m_regs[d] = w;
        else if (d == 64)  npc = w;
        else if (d == 65) begin m_pout[0] = w; m_strobe[0] = 1; end
        else if (d == 66) begin m_pout[1] = w; m_strobe[1] = 1; end
        else if (d == 127) m_halt = 1;
        m_pc = npc;
      end
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  // Drives one clock cycle, samples the combinational ack before the edge, returns at edge+1.
  task automatic cycle(input logic [15:0] ins, input logic iv, input logic [31:0] pd,
                       input logic [1:0] pv, input logic r,
                       output logic [1:0] ack_obs, output logic [1:0] ack_exp);
    instruction = ins; instr_valid = iv; pin_in = pd; pin_in_valid = pv; rst = r;
    #2;
    ack_obs = pin_in_ack;
    model_step(ins, iv, pd, pv, r, ack_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] ins);
    logic [1:0] ao, ae;
    cycle(ins, 1'b1, $urandom, 2'b11, 1'b0, ao, ae);
  endtask

  task automatic do_reset();
    logic [1:0] ao, ae;
    cycle(16'h0441, 1'b1, $urandom, 2'b11, 1'b1, ao, ae);
  endtask

  task automatic test_reset();
    logic [1:0] ao, ae;
    run(16'h0185);
    run(16'h4185);
    cycle(16'h0441, 1'b1, 32'h1234_5678, 2'b11, 1'b1, ao, ae);
    checks++; if (ao !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ao); end
    checks++; if (pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (pin_out !== 32'h0) begin failures++; $display("FAIL reset_pin_out got=%h exp=0", pin_out); end
    checks++; if (pin_out_strobe !== 2'b00) begin failures++; $display("FAIL reset_strobe got=%b exp=00", pin_out_strobe); end
  endtask

  task automatic test_imm_move();
    do_reset();
    run(16'h0185);
    run(16'h0201);
    checks++; if (pc !== 16'd2) begin failures++; $display("FAIL imm_pc got=%h exp=0002", pc); end
    run(16'h4143);
    checks++; if (pin_out[15:0] !== 16'd2) begin failures++; $display("FAIL imm_counter got=%h exp=0002", pin_out[15:0]); end
    run(16'h4102);
    checks++; if (pin_out[15:0] !== 16'd5) begin failures++; $display("FAIL imm_r2 got=%h exp=0005", pin_out[15:0]); end
  endtask

  task automatic test_jump_clear();
    do_reset();
    run(16'h4085);
    checks++; if (pc !== 16'd5) begin failures++; $display("FAIL jump_pc got=%h exp=0005", pc); end
    run(16'h0387);
    run(16'h8303);
    run(16'h4103);
    checks++; if (pin_out[15:0] !== 16'd0) begin failures++; $display("FAIL clear_r3 got=%h exp=0000", pin_out[15:0]); end
    run(16'h8383);
    run(16'h4103);
    checks++; if (pin_out[15:0] !== 16'd3) begin failures++; $display("FAIL i1_imm_r3 got=%h exp=0003", pin_out[15:0]); end
  endtask

  task automatic test_pin_stall();
    logic [1:0] ao, ae;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0441, 1'b1, 32'h0000_BEEF, 2'b00, 1'b0, ao, ae);
      checks++; if (ao !== 2'b00) begin failures++; $display("FAIL stall_ack%0d got=%b exp=00", i, ao); end
      checks++; if (pc !== 16'd0) begin failures++; $display("FAIL stall_pc%0d got=%h exp=0000", i, pc); end
    end
    cycle(16'h0441, 1'b1, 32'h0000_BEEF, 2'b01, 1'b0, ao, ae);
    checks++; if (ao !== 2'b01) begin failures++; $display("FAIL pin_ack got=%b exp=01", ao); end
    checks++; if (pc !== 16'd1) begin failures++; $display("FAIL pin_pc got=%h exp=0001", pc); end
    cycle(16'h4104, 1'b1, 32'h0000_BEEF, 2'b01, 1'b0, ao, ae);
    checks++; if (ao !== 2'b00) begin failures++; $display("FAIL pin_ack_after got=%b exp=00", ao); end
    checks++; if (pin_out[15:0] !== 16'hBEEF) begin failures++; $display("FAIL pin_r4 got=%h exp=beef", pin_out[15:0]); end
  endtask

  task automatic test_pin_out();
    logic [1:0] ao, ae;
    do_reset();
    run(16'h0185);
    run(16'h4101);
    checks++; if (pin_out !== 32'h0000_0005) begin failures++; $display("FAIL pout_ch0 got=%h exp=00000005", pin_out); end
    checks++; if (pin_out_strobe !== 2'b01) begin failures++; $display("FAIL pout_strobe0 got=%b exp=01", pin_out_strobe); end
    cycle(16'h4101, 1'b0, 32'h0, 2'b11, 1'b0, ao, ae);
    checks++; if (pin_out_strobe !== 2'b00) begin failures++; $display("FAIL pout_strobe_end got=%b exp=00", pin_out_strobe); end
    run(16'h4201);
    checks++; if (pin_out !== 32'h0005_0005) begin failures++; $display("FAIL pout_ch1 got=%h exp=00050005", pin_out); end
    checks++; if (pin_out_strobe !== 2'b10) begin failures++; $display("FAIL pout_strobe1 got=%b exp=10", pin_out_strobe); end
  endtask

  task automatic test_halt_wrap();
    logic [1:0] ao, ae;
    do_reset();
    cycle(16'h0541, 1'b1, 32'h0000_FFFF, 2'b01, 1'b0, ao, ae);
    run(16'h4185);
    run(16'h4005);
    checks++; if (pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup_pc got=%h exp=ffff", pc); end
    run(16'h0101);
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    run(16'h7F80);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
    checks++; if (pc !== 16'd1) begin failures++; $display("FAIL halt_pc got=%h exp=0001", pc); end
    for (int i = 0; i < 2; i++) begin
      cycle(16'h4141, 1'b1, 32'h0000_AAAA, 2'b11, 1'b0, ao, ae);
      checks++; if (ao !== 2'b00) begin failures++; $display("FAIL halt_ack%0d got=%b exp=00", i, ao); end
      checks++; if (pc !== 16'd1) begin failures++; $display("FAIL halt_hold_pc%0d got=%h exp=0001", i, pc); end
      checks++; if (pin_out !== 32'h5 || pin_out_strobe !== 2'b00) begin
        failures++; $display("FAIL halt_hold_pout%0d got=%h/%b exp=00000005/00", i, pin_out, pin_out_strobe);
      end
    end
    do_reset();
    checks++; if (halted !== 1'b0 || pc !== 16'd0 || pin_out !== 32'h0) begin
      failures++; $display("FAIL halt_reset got=%b/%h/%h exp=0/0000/00000000", halted, pc, pin_out);
    end
  endtask

  task automatic test_fetch_stall();
    logic [1:0] ao, ae;
    do_reset();
    run(16'h0185);
    for (int i = 0; i < 2; i++) begin
      cycle(16'h4101, 1'b0, 32'h0, 2'b11, 1'b0, ao, ae);
      checks++; if (pc !== 16'd1 || pin_out_strobe !== 2'b00) begin
        failures++; $display("FAIL fstall%0d got=%h/%b exp=0001/00", i, pc, pin_out_strobe);
      end
    end
    run(16'h4143);
    checks++; if (pin_out[15:0] !== 16'd3) begin failures++; $display("FAIL fstall_counter got=%h exp=0003", pin_out[15:0]); end
    run(16'h4101);
    checks++; if (pin_out[15:0] !== 16'd5) begin failures++; $display("FAIL fstall_r1 got=%h exp=0005", pin_out[15:0]); end
  endtask

  function automatic logic [6:0] rnd_addr();
    case ($urandom_range(0, 9))
      5:       return 7'h40;
      6:       return 7'h41;
      7:       return 7'h42;
      8:       return 7'h43;
      9:       return 7'($urandom);
      default: return 7'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic test_random();
    logic [1:0]  ao, ae;
    logic [6:0]  d, s;
    logic        r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      d = rnd_addr();
      s = ($urandom_range(0, 7) == 0) ? d : rnd_addr();
      if (d == 7'h40 && $urandom_range(0, 1) == 0) d = 7'($urandom_range(0, 7));
      r = ($urandom_range(0, 49) == 0);
      cycle({1'($urandom), d, 1'($urandom), s}, ($urandom_range(0, 5) != 0), $urandom,
            2'($urandom), r, ao, ae);
      checks++; if (ao !== ae) begin failures++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, ao, ae); end
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
      checks++; if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, halted, m_halt); end
      checks++; if (pin_out !== {m_pout[1], m_pout[0]}) begin
        failures++; $display("FAIL rnd_pout n=%0d got=%h exp=%h", n, pin_out, {m_pout[1], m_pout[0]});
      end
      checks++; if (pin_out_strobe !== m_strobe) begin
        failures++; $display("FAIL rnd_strobe n=%0d got=%b exp=%b", n, pin_out_strobe, m_strobe);
      end
    end
  endtask

  initial begin
    rst = 1'b1; instruction = 16'h0; instr_valid = 1'b0; pin_in = 32'h0; pin_in_valid = 2'b00;
    do_reset();
    test_reset();
    test_imm_move();
    test_jump_clear();
    test_pin_stall();
    test_pin_out();
    test_halt_wrap();
    test_fetch_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
